// File: rtl/fb_scanout_reader.sv
// Scan-out reader: maps 1280x720 timing onto a 4x-upscaled 320x180 RGB565 frame buffer,
// aligns syncs with BRAM read data and swaps buffers at frame boundaries. Option macro: FB_SCANOUT_TEST_PATTERN_EN.
module fb_scanout_reader #(
  parameter int H_ACTIVE     = 1280,
  parameter int V_ACTIVE     = 720,
  parameter int SCALE_LOG2   = 2,
  parameter int FB_WIDTH     = 320,
  parameter int FB_HEIGHT    = 180,
  parameter int BRAM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  input  logic        pattern_sel_in,
`endif
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        active_draw_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        swap_req_in,
  output logic        swap_ack_out,
  output logic        rd_buf_out,
  output logic [15:0] rd_addr_out,
  input  logic [15:0] rd_data_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out
);

  localparam int          DEPTH      = 1 + BRAM_LATENCY;
  localparam logic [15:0] FB_WIDTH_W = 16'(FB_WIDTH);
  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_PENDING = 1'b1;

  generate
    if (BRAM_LATENCY < 1 || BRAM_LATENCY > 4) begin : g_bad_latency
      $error("fb_scanout_reader: BRAM_LATENCY must be in 1..4");
    end
    if (FB_WIDTH != (H_ACTIVE >> SCALE_LOG2) || FB_HEIGHT != (V_ACTIVE >> SCALE_LOG2)) begin : g_bad_geometry
      $error("fb_scanout_reader: frame-buffer size does not match timing and scale");
    end
    if (FB_WIDTH * FB_HEIGHT > 65536) begin : g_bad_size
      $error("fb_scanout_reader: frame buffer exceeds 16-bit address space");
    end
  endgenerate

  // Stage 1: address = (h >> s) + (v >> s) * FB_WIDTH, multiply unrolled as shift-and-add
  logic [15:0] h_ext, v_ext, h_scaled, v_scaled;
  logic [15:0] row_base [17];
  logic [15:0] rd_addr_next, rd_addr_reg;

  assign h_ext       = {5'd0, hcount_in};
  assign v_ext       = {6'd0, vcount_in};
  assign h_scaled    = h_ext >> SCALE_LOG2;
  assign v_scaled    = v_ext >> SCALE_LOG2;
  assign row_base[0] = '0;

  for (genvar gi = 0; gi < 16; gi++) begin : g_row_mul
    if (FB_WIDTH_W[gi]) begin : g_add
      assign row_base[gi+1] = row_base[gi] + (v_scaled << gi);
    end else begin : g_skip
      assign row_base[gi+1] = row_base[gi];
    end
  end

  assign rd_addr_next = h_scaled + row_base[16];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_addr_reg <= '0;
    end else if (active_draw_in) begin
      rd_addr_reg <= rd_addr_next;
    end
  end

  // Video delay line: final stage lines up with rd_data_in for the matching address
  logic [DEPTH-1:0] hs_pipe_reg, vs_pipe_reg, act_pipe_reg;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hs_pipe_reg  <= '0;
      vs_pipe_reg  <= '0;
      act_pipe_reg <= '0;
    end else begin
      hs_pipe_reg  <= {hs_pipe_reg[DEPTH-2:0], hsync_in};
      vs_pipe_reg  <= {vs_pipe_reg[DEPTH-2:0], vsync_in};
      act_pipe_reg <= {act_pipe_reg[DEPTH-2:0], active_draw_in};
    end
  end

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  // Pattern select and bar index only need to reach the stage feeding the colour register
  logic       pat_pipe_reg [DEPTH-1];
  logic [2:0] bar_pipe_reg [DEPTH-1];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        pat_pipe_reg[i] <= 1'b0;
        bar_pipe_reg[i] <= '0;
      end
    end else begin
      pat_pipe_reg[0] <= pattern_sel_in;
      bar_pipe_reg[0] <= hcount_in[10:8];
      for (int i = 1; i < DEPTH-1; i++) begin
        pat_pipe_reg[i] <= pat_pipe_reg[i-1];
        bar_pipe_reg[i] <= bar_pipe_reg[i-1];
      end
    end
  end
`endif

  // Colour is registered alongside the last delay stage, so it uses the stage feeding it
  logic [7:0] red_next, green_next, blue_next;
  logic [7:0] red_reg, green_reg, blue_reg;

  always_comb begin
    red_next   = {rd_data_in[15:11], rd_data_in[15:13]};
    green_next = {rd_data_in[10:5],  rd_data_in[10:9]};
    blue_next  = {rd_data_in[4:0],   rd_data_in[4:2]};
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    // Bar order white, yellow, cyan, green, magenta, red, blue, black decodes bitwise
    if (pat_pipe_reg[DEPTH-2]) begin
      red_next   = {8{~bar_pipe_reg[DEPTH-2][1]}};
      green_next = {8{~bar_pipe_reg[DEPTH-2][2]}};
      blue_next  = {8{~bar_pipe_reg[DEPTH-2][0]}};
    end
`endif
    if (!act_pipe_reg[DEPTH-2]) begin
      red_next   = '0;
      green_next = '0;
      blue_next  = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      red_reg   <= '0;
      green_reg <= '0;
      blue_reg  <= '0;
    end else begin
      red_reg   <= red_next;
      green_reg <= green_next;
      blue_reg  <= blue_next;
    end
  end

  // Double-buffer swap: only honoured on the first blanking line, so never during active video
  logic       at_boundary, swap_take;
  logic [0:0] state_reg, state_next;
  logic       rd_buf_reg, swap_ack_reg;

  assign at_boundary = (vcount_in == 10'(V_ACTIVE)) && (hcount_in == 11'd0);
  assign swap_take   = at_boundary && (swap_req_in || (state_reg == ST_PENDING));

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_IDLE && swap_req_in && !at_boundary) begin
      state_next = ST_PENDING;
    end else if (state_reg == ST_PENDING && at_boundary) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg    <= ST_IDLE;
      rd_buf_reg   <= 1'b0;
      swap_ack_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      swap_ack_reg <= swap_take;
      if (swap_take) begin
        rd_buf_reg <= ~rd_buf_reg;
      end
    end
  end

  assign rd_addr_out     = rd_addr_reg;
  assign red_out         = red_reg;
  assign green_out       = green_reg;
  assign blue_out        = blue_reg;
  assign hsync_out       = hs_pipe_reg[DEPTH-1];
  assign vsync_out       = vs_pipe_reg[DEPTH-1];
  assign active_draw_out = act_pipe_reg[DEPTH-1];
  assign rd_buf_out      = rd_buf_reg;
  assign swap_ack_out    = swap_ack_reg;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader: vector table for address/colour, hand sequences for
// latency (BRAM_LATENCY 2 and 4), swap handshake and asynchronous reset.
module tb_fb_scanout_reader;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        act, hs, vs, swap_req, pattern_sel;
  logic [15:0] const_data;
  logic        use_model;

  logic        ack1, buf1, ack2, buf2;
  logic [15:0] addr1, addr2, rd1, rd2;
  logic [7:0]  red1, green1, blue1, red2, green2, blue2;
  logic        hs1, vs1, act1, hs2, vs2, act2;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  fb_scanout_reader #(.BRAM_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    .pattern_sel_in(pattern_sel),
`endif
    .hcount_in(hcount), .vcount_in(vcount), .active_draw_in(act),
    .hsync_in(hs), .vsync_in(vs), .swap_req_in(swap_req),
    .swap_ack_out(ack1), .rd_buf_out(buf1), .rd_addr_out(addr1), .rd_data_in(rd1),
    .red_out(red1), .green_out(green1), .blue_out(blue1),
    .hsync_out(hs1), .vsync_out(vs1), .active_draw_out(act1)
  );

  fb_scanout_reader #(.BRAM_LATENCY(4)) dut_l4 (
    .clk_in(clk_in), .rst_in(rst_in),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    .pattern_sel_in(pattern_sel),
`endif
    .hcount_in(hcount), .vcount_in(vcount), .active_draw_in(act),
    .hsync_in(hs), .vsync_in(vs), .swap_req_in(swap_req),
    .swap_ack_out(ack2), .rd_buf_out(buf2), .rd_addr_out(addr2), .rd_data_in(rd2),
    .red_out(red2), .green_out(green2), .blue_out(blue2),
    .hsync_out(hs2), .vsync_out(vs2), .active_draw_out(act2)
  );

  // BRAM model: address 0 holds pure red, everything else pure blue
  logic [15:0] hist1 [4];
  logic [15:0] hist2 [4];

  function automatic logic [15:0] mem(input logic [15:0] a);
    return (a == 16'd0) ? 16'hF800 : 16'h001F;
  endfunction

  always @(posedge clk_in) begin
    hist1[0] <= addr1;
    hist2[0] <= addr2;
    for (int k = 1; k < 4; k++) begin
      hist1[k] <= hist1[k-1];
      hist2[k] <= hist2[k-1];
    end
  end

  assign rd1 = use_model ? mem(hist1[0]) : const_data;
  assign rd2 = use_model ? mem(hist2[2]) : const_data;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        act;
    logic        hs;
    logic        vs;
    logic [15:0] data;
    logic [15:0] exp_addr;
    logic [7:0]  er;
    logic [7:0]  eg;
    logic [7:0]  eb;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first1, first2;
    logic [7:0] r1, g1, b1, r2, g2, b2, blue1_late, blue2_late;

    vecs[0] = '{11'd0,    10'd0,   1'b1, 1'b1, 1'b0, 16'hF800, 16'd0,     8'hFF, 8'h00, 8'h00};
    vecs[1] = '{11'd7,    10'd5,   1'b1, 1'b0, 1'b1, 16'h07E0, 16'd321,   8'h00, 8'hFF, 8'h00};
    vecs[2] = '{11'd1279, 10'd719, 1'b1, 1'b1, 1'b1, 16'h001F, 16'd57599, 8'h00, 8'h00, 8'hFF};
    vecs[3] = '{11'd100,  10'd40,  1'b1, 1'b0, 1'b0, 16'h0841, 16'd3225,  8'h08, 8'h08, 8'h08};
    vecs[4] = '{11'd640,  10'd360, 1'b1, 1'b0, 1'b0, 16'h0821, 16'd28960, 8'h08, 8'h04, 8'h08};
    vecs[5] = '{11'd4,    10'd4,   1'b0, 1'b1, 1'b0, 16'h0841, 16'd28960, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{11'd800,  10'd600, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'd48200, 8'hFF, 8'hFF, 8'hFF};
    vecs[7] = '{11'd1000, 10'd100, 1'b1, 1'b1, 1'b0, 16'hA5A5, 16'd8250,  8'hA5, 8'hB6, 8'h29};

    // Reset with busy inputs: everything must stay at zero
    rst_in = 1'b0; hcount = 11'd9; vcount = 10'd9; act = 1'b1; hs = 1'b1; vs = 1'b1;
    swap_req = 1'b0; pattern_sel = 1'b0; const_data = 16'hFFFF; use_model = 1'b0;
    repeat (3) tick();
    check("reset addr", 32'(addr1), 32'd0);
    check("reset red", 32'(red1), 32'd0);
    check("reset hsync", 32'(hs1), 32'd0);
    check("reset active", 32'(act1), 32'd0);
    check("reset rd_buf", 32'(buf1), 32'd0);
    check("reset ack", 32'(ack1), 32'd0);
    #2 rst_in = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      hcount = vecs[i].hc; vcount = vecs[i].vc; act = vecs[i].act;
      hs = vecs[i].hs; vs = vecs[i].vs; const_data = vecs[i].data;
      tick();
      check($sformatf("row%0d addr", i), 32'(addr1), 32'(vecs[i].exp_addr));
      check($sformatf("row%0d addr_l4", i), 32'(addr2), 32'(vecs[i].exp_addr));
      repeat (4) tick();
      check($sformatf("row%0d red", i), 32'(red1), 32'(vecs[i].er));
      check($sformatf("row%0d green", i), 32'(green1), 32'(vecs[i].eg));
      check($sformatf("row%0d blue", i), 32'(blue1), 32'(vecs[i].eb));
      check($sformatf("row%0d active_out", i), 32'(act1), 32'(vecs[i].act));
      check($sformatf("row%0d hsync_out", i), 32'(hs1), 32'(vecs[i].hs));
      check($sformatf("row%0d vsync_out", i), 32'(vs1), 32'(vecs[i].vs));
      check($sformatf("row%0d rgb_l4", i), {8'd0, red2, green2, blue2},
            {8'd0, vecs[i].er, vecs[i].eg, vecs[i].eb});
    end

    // Latency: active rises at h=0 (address 0 = red), h=4 maps to address 1 (blue)
    use_model = 1'b1; act = 1'b0; hs = 1'b0; vs = 1'b0; hcount = 11'd1270; vcount = 10'd0;
    repeat (6) tick();
    act = 1'b1; hcount = 11'd0;
    first1 = -1; first2 = -1;
    r1 = 8'h55; g1 = 8'h55; b1 = 8'h55; r2 = 8'h55; g2 = 8'h55; b2 = 8'h55;
    blue1_late = 8'h55; blue2_late = 8'h55;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (first1 < 0 && act1) begin first1 = n; r1 = red1; g1 = green1; b1 = blue1; end
      if (first2 < 0 && act2) begin first2 = n; r2 = red2; g2 = green2; b2 = blue2; end
      if (n == 7) blue1_late = blue1;
      if (n == 9) blue2_late = blue2;
      hcount = hcount + 11'd1;
    end
    check("latency l2 cycles", 32'(first1), 32'd3);
    check("latency l2 rgb", {8'd0, r1, g1, b1}, 32'h00FF0000);
    check("latency l2 next pixel blue", 32'(blue1_late), 32'hFF);
    check("latency l4 cycles", 32'(first2), 32'd5);
    check("latency l4 rgb", {8'd0, r2, g2, b2}, 32'h00FF0000);
    check("latency l4 next pixel blue", 32'(blue2_late), 32'hFF);

    // Swap: request mid-frame waits for the boundary; a second request is merged
    use_model = 1'b0; act = 1'b0;
    vcount = 10'd100; hcount = 11'd5; swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("swap early rd_buf", 32'(buf1), 32'd0);
    check("swap early ack", 32'(ack1), 32'd0);
    vcount = 10'd200; hcount = 11'd0; swap_req = 1'b1; tick(); swap_req = 1'b0;
    vcount = 10'd719; tick();
    check("swap pending rd_buf", 32'(buf1), 32'd0);
    vcount = 10'd720; hcount = 11'd0; tick();
    check("swap taken rd_buf", 32'(buf1), 32'd1);
    check("swap taken ack", 32'(ack1), 32'd1);
    hcount = 11'd1; tick();
    check("swap ack one cycle", 32'(ack1), 32'd0);
    hcount = 11'd0; tick();
    check("merged no second toggle", 32'(buf1), 32'd1);
    check("merged no second ack", 32'(ack1), 32'd0);

    // Request exactly on the boundary: immediate swap, FSM stays idle
    hcount = 11'd1; tick();
    hcount = 11'd0; swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("boundary req rd_buf", 32'(buf1), 32'd0);
    check("boundary req ack", 32'(ack1), 32'd1);
    hcount = 11'd1; tick();
    check("boundary req ack drop", 32'(ack1), 32'd0);
    hcount = 11'd0; tick();
    check("boundary req idle after", 32'(buf1), 32'd0);

    // Asynchronous reset while PENDING with rd_buf=1
    hcount = 11'd1; tick();
    hcount = 11'd0; swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("pre-reset rd_buf", 32'(buf1), 32'd1);
    vcount = 10'd50; hcount = 11'd10; swap_req = 1'b1; tick(); swap_req = 1'b0;
    act = 1'b1; hs = 1'b1; vs = 1'b1; const_data = 16'hFFFF;
    repeat (5) tick();
    check("pre-reset red", 32'(red1), 32'hFF);
    #2 rst_in = 1'b0;
    #1;
    check("async reset rgb", {8'd0, red1, green1, blue1}, 32'd0);
    check("async reset syncs", {30'd0, hs1, vs1}, 32'd0);
    check("async reset rd_buf", 32'(buf1), 32'd0);
    check("async reset addr", 32'(addr1), 32'd0);
    #1 rst_in = 1'b1;
    tick(); tick();
    check("refill hsync still low", 32'(hs1), 32'd0);
    check("refill red still black", 32'(red1), 32'd0);
    tick();
    check("refill hsync", 32'(hs1), 32'd1);
    check("refill red", 32'(red1), 32'hFF);
    act = 1'b0; hs = 1'b0; vs = 1'b0;
    vcount = 10'd720; hcount = 11'd0; tick();
    check("post-reset boundary ack", 32'(ack1), 32'd0);
    check("post-reset boundary rd_buf", 32'(buf1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
